bf_program_loader: RTL and testbench

Receives the byte stream from the UART receiver, keeps only the eight Brainfuck command characters and writes them as 3-bit opcodes into program memory. It tracks bracket nesting and stops when the terminator byte arrives. The block sits directly downstream of the UART receiver and upstream of program memory; optionally it echoes each accepted command to the UART transmitter. At completion it reports program length, or an error code.

---
 rtl/bf_pkg.sv | 25 ++
 rtl/bf_char_decode.sv | 26 ++
 rtl/bf_program_loader.sv | 150 +++++++++++++++
 tb/tb_bf_program_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared Brainfuck definitions: opcodes, loader error codes, loader states.
package bf_pkg;

   localparam logic [2:0] OP_INC_PTR = 3'd0;
   localparam logic [2:0] OP_DEC_PTR = 3'd1;
   localparam logic [2:0] OP_INC     = 3'd2;
   localparam logic [2:0] OP_DEC     = 3'd3;
   localparam logic [2:0] OP_OUT     = 3'd4;
   localparam logic [2:0] OP_IN      = 3'd5;
   localparam logic [2:0] OP_JMP_FWD = 3'd6;
   localparam logic [2:0] OP_JMP_BWD = 3'd7;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_UNMATCHED = 2'd1;
   localparam logic [1:0] ERR_UNCLOSED  = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE,
      ST_ERR
   } load_state_t;

endpackage

// File: rtl/bf_char_decode.sv
// Combinational Brainfuck character classifier: byte -> {is_cmd, opcode}.
module bf_char_decode
   import bf_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_cmd,
   output logic [2:0] opcode
);

   always_comb begin
      is_cmd = 1'b1;
      opcode = OP_INC_PTR;
      unique case (ch)
         8'h3E:   opcode = OP_INC_PTR;
         8'h3C:   opcode = OP_DEC_PTR;
         8'h2B:   opcode = OP_INC;
         8'h2D:   opcode = OP_DEC;
         8'h2E:   opcode = OP_OUT;
         8'h2C:   opcode = OP_IN;
         8'h5B:   opcode = OP_JMP_FWD;
         8'h5D:   opcode = OP_JMP_BWD;
         default: is_cmd = 1'b0;
      endcase
   end

endmodule

// File: rtl/bf_program_loader.sv
// Loads Brainfuck commands from the UART byte stream into program memory.
// Optional echo of accepted bytes is enabled by defining BF_LOADER_ECHO_EN.
module bf_program_loader
   import bf_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [7:0]  TERM_CHAR = 8'h21
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              prog_we,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [2:0]        prog_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   prog_len,
   output logic              tx_enable,
   output logic [7:0]        tx_data,
   input  logic              tx_busy
);

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   load_state_t       state, state_n;
   logic [ADDR_W:0]   cnt, cnt_n;
   logic [ADDR_W:0]   depth, depth_n;
   logic [ADDR_W:0]   len_n;
   logic [1:0]        code_n;
   logic              we_n;
   logic [ADDR_W-1:0] addr_n;
   logic [2:0]        wdata_n;
   logic              accept;
   logic              is_cmd;
   logic [2:0]        opcode;

   bf_char_decode u_dec (
      .ch     (rx_data),
      .is_cmd (is_cmd),
      .opcode (opcode)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         depth      <= '0;
         prog_len   <= '0;
         err_code   <= ERR_NONE;
         prog_we    <= 1'b0;
         prog_addr  <= '0;
         prog_wdata <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         depth      <= depth_n;
         prog_len   <= len_n;
         err_code   <= code_n;
         prog_we    <= we_n;
         prog_addr  <= addr_n;
         prog_wdata <= wdata_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      depth_n = depth;
      len_n   = prog_len;
      code_n  = err_code;
      we_n    = 1'b0;
      addr_n  = prog_addr;
      wdata_n = prog_wdata;
      accept  = 1'b0;
      if (start) begin
         state_n = ST_LOAD;
         cnt_n   = '0;
         depth_n = '0;
         len_n   = '0;
         code_n  = ERR_NONE;
      end else if (state == ST_LOAD && rx_valid) begin
         if (is_cmd) begin
            if (cnt == CAP) begin
               state_n = ST_ERR;
               code_n  = ERR_OVERFLOW;
               len_n   = cnt;
            end else if (opcode == OP_JMP_BWD && depth == '0) begin
               state_n = ST_ERR;
               code_n  = ERR_UNMATCHED;
               len_n   = cnt;
            end else begin
               we_n    = 1'b1;
               addr_n  = cnt[ADDR_W-1:0];
               wdata_n = opcode;
               cnt_n   = cnt + ONE;
               accept  = 1'b1;
               if (opcode == OP_JMP_FWD)
                  depth_n = depth + ONE;
               else if (opcode == OP_JMP_BWD)
                  depth_n = depth - ONE;
            end
         end else if (rx_data == TERM_CHAR) begin
            accept = 1'b1;
            len_n  = cnt;
            if (depth == '0) begin
               state_n = ST_DONE;
            end else begin
               state_n = ST_ERR;
               code_n  = ERR_UNCLOSED;
            end
         end
      end
   end

   assign busy  = (state == ST_LOAD);
   assign done  = (state == ST_DONE);
   assign error = (state == ST_ERR);

`ifdef BF_LOADER_ECHO_EN
   // One-entry echo buffer; a newer byte replaces an unsent one.
   logic       echo_full;
   logic [7:0] echo_data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         echo_full <= 1'b0;
         echo_data <= '0;
      end else if (accept) begin
         echo_full <= 1'b1;
         echo_data <= rx_data;
      end else if (tx_enable) begin
         echo_full <= 1'b0;
      end
   end

   assign tx_enable = echo_full & ~tx_busy;
   assign tx_data   = echo_data;
`else
   logic unused_echo;
   assign unused_echo = tx_busy ^ accept;
   assign tx_enable   = 1'b0;
   assign tx_data     = 8'h00;
`endif

endmodule

// File: tb/tb_bf_program_loader.sv
// Self-checking bench for bf_program_loader: vector table, random streams
// against a reference model, and hand-written corner sequences.
module tb_bf_program_loader;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_busy = 1'b0;

   logic       a_we, a_busy, a_done, a_err, a_txen;
   logic [7:0] a_addr, a_txd;
   logic [2:0] a_wd;
   logic [1:0] a_code;
   logic [8:0] a_len;

   logic       b_we, b_busy, b_done, b_err, b_txen;
   logic [1:0] b_addr;
   logic [7:0] b_txd;
   logic [2:0] b_wd;
   logic [1:0] b_code;
   logic [2:0] b_len;

   int n_checks = 0;
   int n_err = 0;
   int q_a[$];
   int q_b[$];
   int exp_ops[$];

   always #5 clock = ~clock;

   bf_program_loader #(.ADDR_W(8)) dut_a (
      .clock(clock), .reset(rst_n), .start(start),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .prog_we(a_we), .prog_addr(a_addr), .prog_wdata(a_wd),
      .busy(a_busy), .done(a_done), .error(a_err),
      .err_code(a_code), .prog_len(a_len),
      .tx_enable(a_txen), .tx_data(a_txd), .tx_busy(tx_busy)
   );

   bf_program_loader #(.ADDR_W(2)) dut_b (
      .clock(clock), .reset(rst_n), .start(start),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .prog_we(b_we), .prog_addr(b_addr), .prog_wdata(b_wd),
      .busy(b_busy), .done(b_done), .error(b_err),
      .err_code(b_code), .prog_len(b_len),
      .tx_enable(b_txen), .tx_data(b_txd), .tx_busy(tx_busy)
   );

   always @(negedge clock) begin
      if (a_we) q_a.push_back(int'(a_addr) * 8 + int'(a_wd));
      if (b_we) q_b.push_back(int'(b_addr) * 8 + int'(b_wd));
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: walk the string by the loader rules; st 0=load 1=done 2=err
   task automatic model(input string s, input int cap,
                        output int st, output int code, output int len);
      string cmds = "><+-.,[]";
      int depth = 0;
      exp_ops.delete();
      st = 0;
      code = 0;
      for (int i = 0; i < s.len(); i++) begin
         int op = -1;
         for (int k = 0; k < 8; k++)
            if (s[i] == cmds[k]) op = k;
         if (op >= 0) begin
            if (exp_ops.size() == cap) begin
               st = 2; code = 3; break;
            end
            if (op == 7 && depth == 0) begin
               st = 2; code = 1; break;
            end
            exp_ops.push_back(op);
            if (op == 6) depth++;
            if (op == 7) depth--;
         end else if (s[i] == 8'h21) begin
            st = (depth == 0) ? 1 : 2;
            code = (depth == 0) ? 0 : 2;
            break;
         end
      end
      len = (st == 0) ? 0 : exp_ops.size();
   endtask

   function automatic int flags(input int st);
      return (st == 0) ? 4 : (st == 1) ? 2 : 1;
   endfunction

   task automatic run_stream(input string s);
      @(negedge clock);
      start = 1'b1;
      rx_valid = 1'b0;
      @(negedge clock);
      start = 1'b0;
      q_a.delete();
      q_b.delete();
      for (int i = 0; i < s.len(); i++) begin
         rx_valid = 1'b1;
         rx_data = s[i];
         @(negedge clock);
      end
      rx_valid = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic chk_writes(input string tag, input bit use_b);
      int n;
      n = use_b ? q_b.size() : q_a.size();
      check({tag, "_nwr"}, n, exp_ops.size());
      if (n == exp_ops.size())
         for (int i = 0; i < n; i++)
            check({tag, "_wr"}, use_b ? q_b[i] : q_a[i], i * 8 + exp_ops[i]);
   endtask

   task automatic chk_model(input string tag, input string s);
      int st, code, len;
      model(s, 256, st, code, len);
      check({tag, "_a_flags"}, int'({a_busy, a_done, a_err}), flags(st));
      check({tag, "_a_code"}, int'(a_code), code);
      check({tag, "_a_len"}, int'(a_len), len);
      chk_writes({tag, "_a"}, 1'b0);
      model(s, 4, st, code, len);
      check({tag, "_b_flags"}, int'({b_busy, b_done, b_err}), flags(st));
      check({tag, "_b_code"}, int'(b_code), code);
      check({tag, "_b_len"}, int'(b_len), len);
      chk_writes({tag, "_b"}, 1'b1);
   endtask

   typedef struct {
      string s;
      int    fl;
      int    code;
      int    len;
   } vec_t;

   initial begin
      vec_t  tbl[8];
      string pool = "><+-.,[][]!ab \n++";
      int    n, d;

      tbl[0] = '{"+[->+<]!", 2, 0, 7};
      tbl[1] = '{"a+ b\n.!", 2, 0, 2};
      tbl[2] = '{"+]",       1, 1, 1};
      tbl[3] = '{"[[]!",     1, 2, 3};
      tbl[4] = '{"]",        1, 1, 0};
      tbl[5] = '{"!",        2, 0, 0};
      tbl[6] = '{"xy+z",     4, 0, 0};
      tbl[7] = '{"[]!++",    2, 0, 2};

      repeat (3) @(negedge clock);
      check("rst_outs", int'(|{a_we, a_addr, a_wd, a_busy, a_done, a_err,
                               a_code, a_len, a_txen, a_txd}), 0);
      rst_n = 1'b1;

      for (int t = 0; t < 8; t++) begin
         run_stream(tbl[t].s);
         check($sformatf("tbl%0d_flags", t),
               int'({a_busy, a_done, a_err}), tbl[t].fl);
         check($sformatf("tbl%0d_code", t), int'(a_code), tbl[t].code);
         check($sformatf("tbl%0d_len", t), int'(a_len), tbl[t].len);
         chk_model($sformatf("tbl%0d", t), tbl[t].s);
      end

      run_stream("+++++");
      check("ovf_nwr", q_b.size(), 4);
      check("ovf_err", int'({b_busy, b_done, b_err}), 1);
      check("ovf_code", int'(b_code), 3);
      check("ovf_len", int'(b_len), 4);
      if (q_b.size() == 4)
         check("ovf_last", q_b[3], 3 * 8 + 2);

      run_stream("+-!");
      run_stream(".!");
      check("restart_nwr", q_a.size(), 1);
      if (q_a.size() == 1)
         check("restart_wr0", q_a[0], 4);

      @(negedge clock);
      start = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'h2B;
      q_a.delete();
      @(negedge clock);
      start = 1'b0;
      rx_valid = 1'b0;
      check("sw_we", int'(a_we), 0);
      check("sw_busy", int'(a_busy), 1);
      repeat (2) @(negedge clock);
      check("sw_nwr", q_a.size(), 0);

      run_stream("+");
      rx_valid = 1'b1;
      rx_data = 8'h2D;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_outs", int'(|{a_we, a_addr, a_wd, a_busy, a_done, a_err,
                                  a_code, a_len}), 0);
      @(negedge clock);
      check("midrst_hold", int'(|{a_we, a_busy, a_done, a_err}), 0);
      rx_valid = 1'b0;
      rst_n = 1'b1;
      check("midrst_nwr", q_a.size(), 1);

      for (int r = 0; r < 60; r++) begin
         string s = "";
         int len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++) begin
            string c = " ";
            c[0] = pool[$urandom_range(0, pool.len() - 1)];
            s = {s, c};
         end
         if ($urandom_range(0, 1) == 1) s = {s, "!"};
         run_stream(s);
         chk_model($sformatf("rnd%0d", r), s);
      end

`ifdef BF_LOADER_ECHO_EN
      tx_busy = 1'b1;
      run_stream("+-");
      check("echo_held", int'(a_txen), 0);
      tx_busy = 1'b0;
      n = 0;
      d = 0;
      repeat (4) begin
         #1;
         if (a_txen) begin
            n++;
            d = int'(a_txd);
         end
         @(negedge clock);
      end
      check("echo_pulses", n, 1);
      check("echo_data", d, 8'h2D);
`else
      n = 0;
      d = 0;
      check("noecho_en", int'(a_txen), n);
      check("noecho_data", int'(a_txd), d);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
